// File: rtl/riscv_fetch_stage.sv
// IF stage: owns the PC, issues word addresses to a 1-cycle synchronous IMEM,
// and feeds the IF/ID register through a 1-entry skid buffer with redirect flush.
module riscv_fetch_stage #(
  parameter int          IMEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  localparam int         A          = $clog2(IMEM_DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         imem_en,
  output logic [A-1:0] imem_addr,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  ifid_ir,
  output logic [31:0]  ifid_pc,
  output logic         ifid_valid
);

  logic [31:0] fpc;
  logic        inflight_vld_p0;
  logic [31:0] inflight_pc_p0;
  logic        skid_vld_p1;
  logic [31:0] skid_ir_p1;
  logic [31:0] skid_pc_p1;
  logic [31:0] redir_tgt;

  assign redir_tgt = {redirect_pc[31:2], 2'b00};

  // Byte-offset bits of the redirect target carry no information.
  logic unused_redir_lsb;
  assign unused_redir_lsb = &{1'b0, redirect_pc[1:0]};

  // Issue: redirect target beats stall; a stalled cycle issues nothing so the skid cannot overflow.
  always_comb begin
    imem_en   = 1'b0;
    imem_addr = fpc[A+1:2];
    if (rst) begin
      imem_en = 1'b0;
    end else if (redirect_valid) begin
      imem_en   = 1'b1;
      imem_addr = redirect_pc[A+1:2];
    end else if (!stall) begin
      imem_en = 1'b1;
    end
  end

  // Control state and IF/ID register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc             <= RESET_PC;
      inflight_vld_p0 <= 1'b0;
      skid_vld_p1     <= 1'b0;
      ifid_ir         <= NOP_INSTR;
      ifid_pc         <= 32'h0;
      ifid_valid      <= 1'b0;
    end else if (redirect_valid) begin
      ifid_ir         <= NOP_INSTR;
      ifid_valid      <= 1'b0;
      skid_vld_p1     <= 1'b0;
      inflight_vld_p0 <= 1'b1;
      fpc             <= redir_tgt + 32'd4;
    end else if (stall) begin
      if (inflight_vld_p0)
        skid_vld_p1 <= 1'b1;
      inflight_vld_p0 <= 1'b0;
    end else begin
      if (skid_vld_p1) begin
        ifid_ir     <= skid_ir_p1;
        ifid_pc     <= skid_pc_p1;
        ifid_valid  <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else if (inflight_vld_p0) begin
        ifid_ir    <= imem_rdata;
        ifid_pc    <= inflight_pc_p0;
        ifid_valid <= 1'b1;
      end else begin
        ifid_ir    <= NOP_INSTR;
        ifid_valid <= 1'b0;
      end
      inflight_vld_p0 <= 1'b1;
      fpc             <= fpc + 32'd4;
    end
  end

  // Datapath registers; their meaning is qualified entirely by the valid flags above.
  always_ff @(posedge clk) begin
    if (redirect_valid)
      inflight_pc_p0 <= redir_tgt;
    else if (!stall)
      inflight_pc_p0 <= fpc;
    if (!redirect_valid && stall && inflight_vld_p0) begin
      skid_ir_p1 <= imem_rdata;
      skid_pc_p1 <= inflight_pc_p0;
    end
  end

endmodule
